// File: rtl/adc_pkg.sv
// Shared types and command-decode constants for the ADC SPI responder.
package adc_pkg;

  localparam logic [2:0]  CMD_REG_ENTER = 3'b101;
  localparam logic [14:0] ADDR_EXIT     = 15'h0014;

  typedef struct packed {
    logic        rw;
    logic [14:0] addr;
    logic [7:0]  data;
  } reg_cmd_t;

  typedef enum logic {CV_IDLE, CV_CONV}  conv_state_t;
  typedef enum logic {FR_IDLE, FR_SHIFT} frame_state_t;

endpackage

// File: rtl/adc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus a one-flop edge detector.
module adc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Quad-SDO ADC emulator: convert/busy handshake, lane-parallel readout and 24-bit command capture.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int unsigned NUM_SDI     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CMD_WIDTH   = 24,
  parameter int unsigned CONV_CYCLES = 50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  sck,
  input  logic                  csn,
  input  logic                  sdi,
  output logic [NUM_SDI-1:0]    sdo,
  input  logic [DATA_WIDTH-1:0] test_pattern,
  output logic                  reg_mode,
  output logic [CMD_WIDTH-1:0]  reg_cmd,
  output logic                  reg_cmd_valid
);

  localparam int unsigned LANE_W = DATA_WIDTH / NUM_SDI;
  localparam int unsigned OW     = $clog2(LANE_W + 1);
  localparam int unsigned CW     = $clog2(CMD_WIDTH + 1);
  localparam int unsigned TW     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

  localparam logic [OW-1:0] LAST_BIT  = OW'(LANE_W - 1);
  localparam logic [OW-1:0] LANE_DONE = OW'(LANE_W);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WIDTH - 1);
  localparam logic [CW-1:0] CMD_FULL  = CW'(CMD_WIDTH);
  localparam logic [TW-1:0] CONV_LOAD = TW'(CONV_CYCLES - 1);

  logic cnv_rise, cnv_level_unused, cnv_fall_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic csn_rise, csn_fall, csn_level_unused;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnv (
    .clk(clk), .reset(reset), .d(cnv),
    .level(cnv_level_unused), .rise(cnv_rise), .fall(cnv_fall_unused));

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall));

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .reset(reset), .d(csn),
    .level(csn_level_unused), .rise(csn_rise), .fall(csn_fall));

  // sdi shares the sck pipeline depth so its level lines up with the sck edge pulse
  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi),
    .level(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  conv_state_t           conv_state_q, conv_state_d;
  frame_state_t          frame_state_q, frame_state_d;
  logic [TW-1:0]         conv_cnt_q, conv_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [OW-1:0]         out_cnt_q, out_cnt_d;
  logic [NUM_SDI-1:0]    sdo_q, sdo_d;
  logic [CMD_WIDTH-1:0]  cmd_sr_q, cmd_sr_d;
  logic [CW-1:0]         cmd_cnt_q, cmd_cnt_d;
  logic [CMD_WIDTH-1:0]  reg_cmd_q, reg_cmd_d;
  logic                  reg_cmd_valid_q, reg_cmd_valid_d;
  logic                  reg_mode_q, reg_mode_d;
  reg_cmd_t              cmd;

  function automatic logic [NUM_SDI-1:0] lane_msbs(input logic [DATA_WIDTH-1:0] w);
    logic [NUM_SDI-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NUM_SDI; k++) m[k] = w[(k+1)*LANE_W-1];
    return m;
  endfunction

  // Shift every lane left by one; clear each lane LSB so no bit leaks across lanes.
  function automatic logic [DATA_WIDTH-1:0] lane_shift(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] s;
    s = w << 1;
    for (int unsigned k = 0; k < NUM_SDI; k++) s[k*LANE_W] = 1'b0;
    return s;
  endfunction

  always_comb begin
    conv_state_d    = conv_state_q;
    frame_state_d   = frame_state_q;
    conv_cnt_d      = conv_cnt_q;
    word_d          = word_q;
    shift_d         = shift_q;
    out_cnt_d       = out_cnt_q;
    sdo_d           = sdo_q;
    cmd_sr_d        = cmd_sr_q;
    cmd_cnt_d       = cmd_cnt_q;
    reg_cmd_d       = reg_cmd_q;
    reg_cmd_valid_d = 1'b0;
    reg_mode_d      = reg_mode_q;
    cmd             = reg_cmd_t'(reg_cmd_q);

    case (conv_state_q)
      CV_IDLE: begin
        if (cnv_rise && !reg_mode_q) begin
          conv_state_d = CV_CONV;
          conv_cnt_d   = CONV_LOAD;
        end
      end
      CV_CONV: begin
        if (conv_cnt_q == '0) begin
          conv_state_d = CV_IDLE;
          word_d       = test_pattern;
        end else begin
          conv_cnt_d = conv_cnt_q - TW'(1);
        end
      end
      default: conv_state_d = CV_IDLE;
    endcase

    // Register-mode reads return 8'h00 on lane 0, so every lane is simply held low.
    if (csn_rise) begin
      frame_state_d = FR_IDLE;
      sdo_d         = '0;
    end else if (csn_fall) begin
      frame_state_d = FR_SHIFT;
      shift_d       = word_q;
      out_cnt_d     = '0;
      cmd_cnt_d     = '0;
      sdo_d         = reg_mode_q ? '0 : lane_msbs(word_q);
    end else if (frame_state_q == FR_SHIFT) begin
      if (sck_fall && out_cnt_q != LANE_DONE) begin
        out_cnt_d = out_cnt_q + OW'(1);
        shift_d   = lane_shift(shift_q);
        sdo_d     = (out_cnt_q < LAST_BIT && !reg_mode_q) ? lane_msbs(shift_d) : '0;
      end
      if (sck_rise && cmd_cnt_q != CMD_FULL) begin
        cmd_sr_d  = {cmd_sr_q[CMD_WIDTH-2:0], sdi_s};
        cmd_cnt_d = cmd_cnt_q + CW'(1);
        if (cmd_cnt_q == CMD_LAST) begin
          reg_cmd_d       = cmd_sr_d;
          reg_cmd_valid_d = 1'b1;
        end
      end
    end

    if (reg_cmd_valid_q) begin
      if (!reg_mode_q && {cmd.rw, cmd.addr[14:13]} == CMD_REG_ENTER)
        reg_mode_d = 1'b1;
      else if (reg_mode_q && !cmd.rw && cmd.addr == ADDR_EXIT && cmd.data[0])
        reg_mode_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_state_q    <= CV_IDLE;
      frame_state_q   <= FR_IDLE;
      conv_cnt_q      <= '0;
      word_q          <= '0;
      shift_q         <= '0;
      out_cnt_q       <= '0;
      sdo_q           <= '0;
      cmd_sr_q        <= '0;
      cmd_cnt_q       <= '0;
      reg_cmd_q       <= '0;
      reg_cmd_valid_q <= 1'b0;
      reg_mode_q      <= 1'b0;
    end else begin
      conv_state_q    <= conv_state_d;
      frame_state_q   <= frame_state_d;
      conv_cnt_q      <= conv_cnt_d;
      word_q          <= word_d;
      shift_q         <= shift_d;
      out_cnt_q       <= out_cnt_d;
      sdo_q           <= sdo_d;
      cmd_sr_q        <= cmd_sr_d;
      cmd_cnt_q       <= cmd_cnt_d;
      reg_cmd_q       <= reg_cmd_d;
      reg_cmd_valid_q <= reg_cmd_valid_d;
      reg_mode_q      <= reg_mode_d;
    end
  end

  assign busy          = (conv_state_q == CV_CONV);
  assign sdo           = sdo_q;
  assign reg_mode      = reg_mode_q;
  assign reg_cmd       = reg_cmd_q;
  assign reg_cmd_valid = reg_cmd_valid_q;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
Synthesizable ADC-side SPI target emulating the quad-SDO ADC. It is the responder to adc_spi_controller and is used for on-fabric loopback and hardware-in-loop tests without a physical ADC. It handles the convert/busy handshake, shifts a latched conversion word out on NUM_SDI lanes, and captures 24-bit register commands from the controller's SDO. All SPI inputs are oversampled by the system clock; no logic runs on sck.

Parameters:
NUM_SDI, 4, number of data-out lanes; must divide DATA_WIDTH
DATA_WIDTH, 32, conversion word width
CMD_WIDTH, 24, register command width {rw, addr[14:0], data[7:0]}
CONV_CYCLES, 50, busy duration in clk cycles; minimum 1
SYNC_STAGES, 2, synchronizer depth for cnv/sck/csn/sdi; minimum 2

Ports:
clk  in  1  system clock; must be at least 4x the sck frequency
reset  in  1  synchronous, active-high reset
cnv  in  1  convert start; async, rising-edge triggered
busy  out  1  high while a conversion is in progress
sck  in  1  SPI clock from the controller; async, idle low
csn  in  1  SPI chip select; active low, async
sdi  in  1  serial command data (controller spi_sdo)
sdo  out  NUM_SDI  serial data lanes (controller spi_sdi)
test_pattern  in  DATA_WIDTH  word latched at end of conversion
reg_mode  out  1  1 = register-access mode, 0 = conversion mode
reg_cmd  out  CMD_WIDTH  last complete command received
reg_cmd_valid  out  1  one-cycle pulse when reg_cmd updates

Behaviour:
- Reset (sampled on clk rise while reset=1): busy=0, sdo=0, reg_mode=0, reg_cmd=0, reg_cmd_valid=0. Latched word=0, bit counters=0, conversion counter=0, synchronizers cleared. Reset mid-frame or mid-conversion aborts both immediately.
- Inputs pass through SYNC_STAGES flops, then a one-flop edge detector. All latencies below are counted from the synchronized edge.
- Conversion FSM, states IDLE and CONV:
  - IDLE -> CONV on a cnv rising edge. busy=1 in the same cycle; counter loads CONV_CYCLES-1.
  - CONV: counter decrements each cycle; at 0 -> IDLE. busy=0 and the latched word <= test_pattern in that transition cycle. busy is high for exactly CONV_CYCLES cycles.
  - cnv edges during CONV are ignored.
  - cnv is ignored while reg_mode=1.
- Frame FSM, states IDLE and SHIFT:
  - csn fall -> SHIFT. Bit counter=0; shift register loads the latched word.
  - A read during CONV returns the previous word.
  - csn rise -> IDLE in any state. Partial command is discarded, no valid pulse.
- Data lanes in conversion mode:
  - Lane k carries word bits [(k+1)*W-1 : k*W], where W = DATA_WIDTH/NUM_SDI. MSB first.
  - The first bit drives at csn fall. Each sck falling edge advances to the next bit.
  - Latency is 1 clk after the synchronized edge; the controller samples on sck rise.
  - After W bits, sdo holds 0.
- Command capture:
  - sdi is sampled on each sck rising edge, MSB first, into a CMD_WIDTH shift register.
  - On the CMD_WIDTH-th rising edge: reg_cmd <= captured word and reg_cmd_valid pulses on the next cycle.
  - Additional sck edges in the same frame are ignored until csn rises.
- Register reads in reg_mode (rw=1): sdo[0] drives 8'h00 during bits 16-23. All other lanes stay 0.
- Mode transitions, evaluated on the valid cycle:
  - In conversion mode, command bits [23:21]==3'b101 -> reg_mode=1 on the next cycle.
  - In reg_mode, a write (rw=0) to addr 15'h0014 with data[0]=1 -> reg_mode=0.
  - All other commands leave the mode unchanged.
- sdo=0 whenever csn is high.

Decomposition:
- Package adc_pkg holds:
  - CMD_REG_ENTER = 3'b101
  - ADDR_EXIT = 15'h0014
  - typedef reg_cmd_t, a packed struct {rw, addr, data}
  - enum conv_state_t {IDLE, CONV}
  - enum frame_state_t {IDLE, SHIFT}
- Sub-module adc_sync_edge: parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated once per async input.

Test Plan:
- Hold reset 5 cycles, then release -> all outputs 0, reg_mode=0. Apply cnv while reset is high -> busy stays 0.
- Set test_pattern=32'h8BADF00D and pulse cnv -> busy high exactly 50 clk. Run an 8-sck frame -> lanes 3..0 deliver 8'h8B, 8'hAD, 8'hF0, 8'h0D.
- Send 24'hA00000 -> reg_cmd_valid pulses once, reg_cmd=24'hA00000, reg_mode=1. Send 24'h001501 -> reg_mode stays 1. Send 24'h001401 -> reg_mode=0.
- Raise csn after 12 sck edges in reg_mode -> no reg_cmd_valid pulse, reg_cmd unchanged, the next full frame decodes correctly.
- Second cnv 10 cycles into a conversion -> busy still ends at cycle 50. Read during busy after setting test_pattern=32'h0023FF42 -> returns the old word. The next read after busy falls returns 32'h0023FF42.
- Assert reset in the middle of a conversion frame -> busy=0 and sdo=0 on the next clk. Send cnv in reg_mode -> busy stays 0.
